// File: rtl/ysyx_23060208_bus_pkg.sv
// Shared constants for the memory-port arbiter:
// FSM state encoding and master indices.
package ysyx_23060208_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic M_IFU = 1'b0;
   localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060208_rr_arb2.sv
// Two-way combinational round-robin picker;
// on a tie the master that did not win last time is granted.
module ysyx_23060208_rr_arb2
   import ysyx_23060208_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (&req) begin
         gnt = (last_grant == M_LSU) ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/ysyx_23060208_mem_arbiter.sv
// IFU/LSU arbiter for the single memory port,
// one outstanding transaction, response routed to its owner.
module ysyx_23060208_mem_arbiter
   import ysyx_23060208_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    m0_req_valid,
   output logic                    m0_req_ready,
   input  logic                    m0_req_wen,
   input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
   input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] m0_req_wstrb,
   output logic                    m0_resp_valid,
   input  logic                    m0_resp_ready,
   output logic [DATA_WIDTH-1:0]   m0_resp_rdata,
   input  logic                    m1_req_valid,
   output logic                    m1_req_ready,
   input  logic                    m1_req_wen,
   input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
   input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] m1_req_wstrb,
   output logic                    m1_resp_valid,
   input  logic                    m1_resp_ready,
   output logic [DATA_WIDTH-1:0]   m1_resp_rdata,
   output logic                    s_req_valid,
   input  logic                    s_req_ready,
   output logic                    s_req_wen,
   output logic [ADDR_WIDTH-1:0]   s_req_addr,
   output logic [DATA_WIDTH-1:0]   s_req_wdata,
   output logic [DATA_WIDTH/8-1:0] s_req_wstrb,
   input  logic                    s_resp_valid,
   output logic                    s_resp_ready,
   input  logic [DATA_WIDTH-1:0]   s_resp_rdata
);

   localparam int STRB_W = DATA_WIDTH / 8;

   state_t              state;
   state_t              state_nxt;
   logic                owner;
   logic                last_grant;
   logic [1:0]          gnt;
   logic                accept;
   logic                sel;
   logic                wen_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]   wstrb_q;

   ysyx_23060208_rr_arb2 u_arb (
      .req        ({m1_req_valid, m0_req_valid}),
      .last_grant (last_grant),
      .gnt        (gnt)
   );

   assign accept = (state == IDLE) && (|gnt);
   assign sel    = gnt[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= M_IFU;
         last_grant <= M_LSU;
         wen_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner      <= sel;
            last_grant <= sel;
            wen_q      <= sel ? m1_req_wen   : m0_req_wen;
            addr_q     <= sel ? m1_req_addr  : m0_req_addr;
            wdata_q    <= sel ? m1_req_wdata : m0_req_wdata;
            wstrb_q    <= sel ? m1_req_wstrb : m0_req_wstrb;
         end
      end
   end

   assign s_req_wen   = wen_q;
   assign s_req_addr  = addr_q;
   assign s_req_wdata = wdata_q;
   assign s_req_wstrb = wstrb_q;

   always_comb begin
      state_nxt     = state;
      m0_req_ready  = 1'b0;
      m1_req_ready  = 1'b0;
      s_req_valid   = 1'b0;
      s_resp_ready  = 1'b0;
      m0_resp_valid = 1'b0;
      m1_resp_valid = 1'b0;
      m0_resp_rdata = '0;
      m1_resp_rdata = '0;
      unique case (state)
         IDLE: begin
            m0_req_ready = gnt[0];
            m1_req_ready = gnt[1];
            if (accept) state_nxt = REQ;
         end
         REQ: begin
            s_req_valid = 1'b1;
            if (s_req_ready) state_nxt = WAIT;
         end
         WAIT: begin
            if (owner == M_LSU) begin
               m1_resp_valid = s_resp_valid;
               m1_resp_rdata = s_resp_rdata;
               s_resp_ready  = m1_resp_ready;
            end else begin
               m0_resp_valid = s_resp_valid;
               m0_resp_rdata = s_resp_rdata;
               s_resp_ready  = m0_resp_ready;
            end
            if (s_resp_valid && s_resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ysyx_23060208_mem_arbiter.sv
// Self-checking bench: table vectors, hand-written reset and
// spurious-response sequences, then randomized transactions.
module tb_ysyx_23060208_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req_valid, m0_req_ready, m0_req_wen;
   logic [31:0] m0_req_addr, m0_req_wdata;
   logic [3:0]  m0_req_wstrb;
   logic        m0_resp_valid, m0_resp_ready;
   logic [31:0] m0_resp_rdata;
   logic        m1_req_valid, m1_req_ready, m1_req_wen;
   logic [31:0] m1_req_addr, m1_req_wdata;
   logic [3:0]  m1_req_wstrb;
   logic        m1_resp_valid, m1_resp_ready;
   logic [31:0] m1_resp_rdata;
   logic        s_req_valid, s_req_ready, s_req_wen;
   logic [31:0] s_req_addr, s_req_wdata;
   logic [3:0]  s_req_wstrb;
   logic        s_resp_valid, s_resp_ready;
   logic [31:0] s_resp_rdata;

   int vecs = 0;
   int miss = 0;
   int nhs  = 0;
   bit prev = 1'b1;

   always #5 clk = ~clk;

   ysyx_23060208_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
      .m0_req_wen(m0_req_wen), .m0_req_addr(m0_req_addr),
      .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
      .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
      .m0_resp_rdata(m0_resp_rdata),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
      .m1_req_wen(m1_req_wen), .m1_req_addr(m1_req_addr),
      .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
      .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
      .m1_resp_rdata(m1_resp_rdata),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
      .s_req_wen(s_req_wen), .s_req_addr(s_req_addr),
      .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb),
      .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
      .s_resp_rdata(s_resp_rdata)
   );

   always @(negedge clk) begin
      if (s_req_valid && s_req_ready) nhs++;
   end

   typedef struct {
      bit          v0;
      bit          v1;
      bit          wen1;
      logic [31:0] a1;
      logic [31:0] d1;
      logic [3:0]  st1;
      int          sreq;
      int          sresp;
      int          rr;
      logic [31:0] rd;
      bit          exp;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      vecs++;
      if (a !== e) begin
         miss++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   function automatic bit ref_pick(input bit v0, input bit v1);
      if (v0 && v1) return ~prev;
      return v1;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string n);
      chk({n, "_r0"}, m0_req_ready, 0);
      chk({n, "_r1"}, m1_req_ready, 0);
   endtask

   task automatic do_txn(input bit v0, input bit v1, input int sreq,
                         input int sresp, input int rr,
                         input logic [31:0] rd, input bit w);
      logic [31:0] ea, ed;
      logic [3:0]  es;
      logic        ew;
      int          n0;
      ew = w ? m1_req_wen   : m0_req_wen;
      ea = w ? m1_req_addr  : m0_req_addr;
      ed = w ? m1_req_wdata : m0_req_wdata;
      es = w ? m1_req_wstrb : m0_req_wstrb;
      n0 = nhs;
      m0_req_valid = v0;
      m1_req_valid = v1;
      s_req_ready  = 0;
      s_resp_valid = 0;
      m0_resp_ready = 0;
      m1_resp_ready = 0;
      @(negedge clk);
      chk("gnt0", m0_req_ready, 32'(w == 0));
      chk("gnt1", m1_req_ready, 32'(w == 1));
      cyc();
      if (w) m1_req_valid = 0;
      else   m0_req_valid = 0;
      for (int i = 0; i <= sreq; i++) begin
         s_req_ready  = (i == sreq);
         s_resp_valid = 1'($urandom);
         s_resp_rdata = $urandom;
         @(negedge clk);
         chk("s_valid", s_req_valid, 1);
         chk("s_wen", s_req_wen, ew);
         chk("s_addr", s_req_addr, ea);
         chk("s_wdata", s_req_wdata, ed);
         chk("s_wstrb", s_req_wstrb, es);
         chk("req_rv0", m0_resp_valid, 0);
         chk("req_rv1", m1_resp_valid, 0);
         chk("req_srr", s_resp_ready, 0);
         chk_quiet("req");
         cyc();
      end
      s_req_ready  = 0;
      s_resp_valid = 0;
      chk("one_write", nhs, n0 + 1);
      for (int i = 0; i < sresp; i++) begin
         if (w) m1_resp_ready = 1'($urandom);
         else   m0_resp_ready = 1'($urandom);
         @(negedge clk);
         chk("wt_sv", s_req_valid, 0);
         chk("wt_rv0", m0_resp_valid, 0);
         chk("wt_rv1", m1_resp_valid, 0);
         chk_quiet("wt");
         cyc();
      end
      s_resp_valid = 1;
      s_resp_rdata = rd;
      for (int i = 0; i <= rr; i++) begin
         m0_resp_ready = (w == 0) && (i == rr);
         m1_resp_ready = (w == 1) && (i == rr);
         @(negedge clk);
         chk("own_rv", w ? m1_resp_valid : m0_resp_valid, 1);
         chk("oth_rv", w ? m0_resp_valid : m1_resp_valid, 0);
         chk("oth_rd", w ? m0_resp_rdata : m1_resp_rdata, 0);
         chk("own_rd", w ? m1_resp_rdata : m0_resp_rdata, rd);
         chk("s_rr", s_resp_ready, 32'(i == rr));
         chk_quiet("rsp");
         cyc();
      end
      s_resp_valid  = 0;
      m0_resp_ready = 0;
      m1_resp_ready = 0;
      m0_req_valid  = 0;
      m1_req_valid  = 0;
      prev = w;
   endtask

   initial begin
      rst = 1;
      {m0_req_valid, m0_req_wen, m0_resp_ready} = '0;
      {m1_req_valid, m1_req_wen, m1_resp_ready} = '0;
      m0_req_addr = 0; m0_req_wdata = 0; m0_req_wstrb = 0;
      m1_req_addr = 0; m1_req_wdata = 0; m1_req_wstrb = 0;
      s_req_ready = 0; s_resp_valid = 0; s_resp_rdata = 0;

      tbl[0] = '{1, 1, 1, 32'h20, 32'hA5A5_0001, 4'hF, 0, 0, 0, 32'h1111_1111, 0};
      tbl[1] = '{1, 1, 1, 32'h24, 32'hA5A5_0002, 4'hF, 0, 1, 0, 32'h2222_2222, 1};
      tbl[2] = '{1, 1, 0, 32'h28, 32'h0, 4'h0, 1, 0, 0, 32'h3333_3333, 0};
      tbl[3] = '{1, 1, 1, 32'h2C, 32'hA5A5_0004, 4'h1, 0, 0, 1, 32'h4444_4444, 1};
      tbl[4] = '{1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'hDEAD_BEEF, 0};
      tbl[5] = '{0, 1, 1, 32'h10, 32'h1234_5678, 4'b0011, 3, 0, 0, 32'h0BAD_F00D, 1};
      tbl[6] = '{1, 1, 1, 32'h30, 32'h5555_AAAA, 4'hC, 0, 1, 2, 32'h6666_6666, 0};
      tbl[7] = '{0, 1, 0, 32'h34, 32'h0, 4'h0, 0, 2, 0, 32'h7777_7777, 1};
      tbl[8] = '{1, 1, 1, 32'h38, 32'h9999_0000, 4'h8, 1, 1, 1, 32'h8888_8888, 0};

      @(negedge clk);
      chk("rst_sv", s_req_valid, 0);
      chk("rst_srr", s_resp_ready, 0);
      chk("rst_rv0", m0_resp_valid, 0);
      chk("rst_rv1", m1_resp_valid, 0);
      chk_quiet("rst");
      cyc();
      rst = 0;

      for (int i = 0; i < 9; i++) begin
         m0_req_wen   = 0;
         m0_req_addr  = 32'h8000_0000 + 32'(4 * i);
         m0_req_wdata = $urandom;
         m0_req_wstrb = 4'(i);
         m1_req_wen   = tbl[i].wen1;
         m1_req_addr  = tbl[i].a1;
         m1_req_wdata = tbl[i].d1;
         m1_req_wstrb = tbl[i].st1;
         do_txn(tbl[i].v0, tbl[i].v1, tbl[i].sreq, tbl[i].sresp,
                tbl[i].rr, tbl[i].rd, tbl[i].exp);
      end

      // valid raised and dropped between edges: no grant, no state change
      m1_req_valid = 1;
      #2 chk("drop_rdy", m1_req_ready, 1);
      m1_req_valid = 0;
      cyc();
      @(negedge clk);
      chk("drop_sv", s_req_valid, 0);
      cyc();

      // reset in the middle of WAIT drops the transaction
      m0_req_valid = 1;
      m0_req_addr  = 32'h8000_1000;
      cyc();
      m0_req_valid = 0;
      s_req_ready  = 1;
      cyc();
      s_req_ready = 0;
      @(negedge clk);
      chk("mid_sv", s_req_valid, 0);
      #2 rst = 1;
      #2 rst = 0;
      chk("rr_sv", s_req_valid, 0);
      chk("rr_srr", s_resp_ready, 0);
      chk("rr_rv0", m0_resp_valid, 0);
      chk("rr_rv1", m1_resp_valid, 0);
      prev = 1;
      cyc();
      s_resp_valid  = 1;
      s_resp_rdata  = 32'hCAFE_F00D;
      m0_resp_ready = 1;
      @(negedge clk);
      chk("late_rv0", m0_resp_valid, 0);
      chk("late_rd0", m0_resp_rdata, 0);
      chk("late_srr", s_resp_ready, 0);
      chk_quiet("late");
      cyc();
      do_txn(1, 0, 0, 0, 0, 32'h0102_0304, 0);

      // spurious slave response in IDLE with no requests
      s_resp_valid  = 1;
      m1_resp_ready = 1;
      @(negedge clk);
      chk("sp_rv0", m0_resp_valid, 0);
      chk("sp_rv1", m1_resp_valid, 0);
      chk("sp_srr", s_resp_ready, 0);
      cyc();

      for (int k = 0; k < 40; k++) begin
         bit v0, v1;
         v0 = 1'($urandom);
         v1 = 1'($urandom);
         if (!v0 && !v1) v0 = 1;
         m0_req_wen   = 0;
         m0_req_addr  = $urandom;
         m0_req_wdata = $urandom;
         m0_req_wstrb = 4'($urandom);
         m1_req_wen   = 1'($urandom);
         m1_req_addr  = $urandom;
         m1_req_wdata = $urandom;
         m1_req_wstrb = 4'($urandom);
         do_txn(v0, v1, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), $urandom, ref_pick(v0, v1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
